dma_reference_model: RTL and testbench
======================================

// Module: dma_reference_model
// PURPOSE
//  Cycle-accurate decode model of the 8237-style DMA controller's CPU programming interface.
//  Watches CS_N/IOR_N/IOW_N/A[3:0] while the DMA is in program condition.
//  Emits per-register load/read strobes and tracks the byte-pointer flip-flop.
//  Runs beside the DMA RTL so checkers can compare register updates against its strobes.
// PARAMETERS
//  (none) - all widths fixed by the 8237 register map
// PORTS
//  CLK                       in   1  single clock; all state on rising edge
//  RESET_N                   in   1  asynchronous, active-low reset
//  CS_N                      in   1  chip select, active low
//  IOR_N                     in   1  I/O read strobe, active low
//  IOW_N                     in   1  I/O write strobe, active low
//  A                         in   4  A3..A0 register address
//  programCondition          in   1  1 = CPU may program the DMA (idle, no HLDA)
//  loadCommandReg            out  1  write command register (A=1000)
//  loadModeReg               out  1  write mode register (A=1011)
//  loadBaseAddressReg        out  1  write base/current address, channel A[2:1] (A3=0,A0=0)
//  loadBaseWordCountReg      out  1  write base/current word count (A3=0,A0=1)
//  clearInternalFF           out  1  clear byte pointer (write A=1100)
//  masterClear               out  1  master clear (write A=1101)
//  readStatusReg             out  1  read status (read A=1000)
//  readCurrentAddressReg     out  1  read current address (read A3=0,A0=0)
//  readCurrentWordCountReg   out  1  read current word count (read A3=0,A0=1)
//  loadIoDataBufferFromStatus out 1  load I/O data buffer from status register
//  channelSel                out  2  channel of last channel-register access (A[2:1])
//  upperByte                 out  1  byte-pointer FF: 0 = low byte next, 1 = high byte next
//  loadRequestReg/loadMaskBit/clearMaskReg/loadAllMask  out 1 each  (mask decodes, see CONFIGURATION)
// BEHAVIOUR
//  - access valid = !CS_N & programCondition & (IOR_N ^ IOW_N); IOR_N=IOW_N=0 is illegal -> no strobes.
//  - read* outputs are combinational levels while a valid read is in progress.
//  - Write strobes (load*, clear*, masterClear, mask decodes) are registered one-cycle pulses.
//    They fire in the cycle after the first cycle of a valid write, once per IOW_N low phase.
//  - An address change while IOW_N stays low produces no new strobe.
//  - loadIoDataBufferFromStatus = readStatusReg delayed one cycle; pulses once per read phase.
//  - channelSel updates with each channel-register strobe and holds otherwise.
//  - upperByte:
//    - toggles on each registered channel-register access strobe, read or write.
//      Read strobe is internal: first cycle of read phase, delayed one cycle.
//    - cleared by clearInternalFF or masterClear; clear wins over a simultaneous toggle.
//  - Reserved/unused decodes (read A=1001..1111 except 1101) generate no strobe.
//    readTemporaryReg is not modelled.
//  - Reset (async, RESET_N=0): all registered outputs 0, upperByte=0, channelSel=0, edge trackers idle.
//  - Reset mid-access: the pending strobe is dropped.
//    After release, a write still held low does not strobe until IOW_N rises and falls again.
// CONFIGURATION
//  MASK_DECODE_EN defined:
//    - loadRequestReg (1001), loadMaskBit (1010), clearMaskReg (1110), loadAllMask (1111)
//      decode as registered write pulses.
//    - masterClear (1101) additionally pulses clearMaskReg.
//  MASK_DECODE_EN undefined: these four outputs are tied 0; all else unchanged.
// STRUCTURE
//  - Package dma_ref_pkg: 4-bit address localparams (ADDR_CMD=4'h8 ... ADDR_ALLMASK=4'hF).
//    Also an access-type enum {ACC_NONE, ACC_RD, ACC_WR}.
//  - Sub-module dma_addr_decode: purely combinational A/access -> one-hot decode.
//    The top level adds edge detection, output registers, byte-pointer FF and channelSel.
// TESTING
//  - Write A=1000 (CS_N=0, IOW_N low 2 cycles, progCond=1) -> loadCommandReg=1 exactly 1 cycle, cycle after IOW_N falls.
//  - Two writes A=0100 after write A=1100 -> loadBaseAddressReg pulses twice; channelSel=2; upperByte 0->1->0.
//  - Read A=1000 -> readStatusReg high while IOR_N low; loadIoDataBufferFromStatus single pulse one cycle later.
//  - progCond=0 or CS_N=1 or IOR_N=IOW_N=0 with A=1011 -> no strobes at all.
//  - RESET_N=0 mid-write A=1011 -> loadModeReg stays 0; outputs 0 immediately; upperByte=0.
//  - MASK_DECODE_EN defined, write A=1111 -> loadAllMask pulse.
//    Undefined -> loadAllMask stays 0 and no other strobe fires.

Source files
------------

// File: rtl/dma_ref_pkg.sv
// Shared register-map addresses, access classification and decode bundles for the
// 8237 programming-interface reference model.
package dma_ref_pkg;

   localparam logic [3:0] ADDR_CMD     = 4'h8;
   localparam logic [3:0] ADDR_STATUS  = 4'h8;
   localparam logic [3:0] ADDR_REQ     = 4'h9;
   localparam logic [3:0] ADDR_MASKBIT = 4'hA;
   localparam logic [3:0] ADDR_MODE    = 4'hB;
   localparam logic [3:0] ADDR_CLRFF   = 4'hC;
   localparam logic [3:0] ADDR_MCLR    = 4'hD;
   localparam logic [3:0] ADDR_CLRMASK = 4'hE;
   localparam logic [3:0] ADDR_ALLMASK = 4'hF;

   typedef enum logic [1:0] {ACC_NONE, ACC_RD, ACC_WR} accType_t;

   typedef struct packed {
      logic cmd;
      logic mode;
      logic baseAddr;
      logic baseCount;
      logic clrFF;
      logic mClr;
      logic request;
      logic maskBit;
      logic clrMask;
      logic allMask;
   } wrDec_t;

   typedef struct packed {
      logic status;
      logic curAddr;
      logic curCount;
   } rdDec_t;

   // Simultaneous IOR_N/IOW_N low is illegal and classifies as no access.
   function automatic accType_t accessType(input logic csN, input logic iorN,
                                           input logic iowN, input logic progCond);
      if (csN || !progCond || !(iorN ^ iowN)) return ACC_NONE;
      return iorN ? ACC_WR : ACC_RD;
   endfunction

endpackage

// File: rtl/dma_addr_decode.sv
// Combinational A[3:0]/access-type to one-hot register decode.
// Optional mask-register decodes are compiled in with MASK_DECODE_EN.
module dma_addr_decode
   import dma_ref_pkg::*;
(
   input  logic [3:0] A,
   input  accType_t   acc,
   output wrDec_t     wrDec,
   output rdDec_t     rdDec
);

   always_comb begin
      wrDec = '0;
      rdDec = '0;
      if (acc == ACC_WR) begin
         if (!A[3]) begin
            wrDec.baseAddr  = !A[0];
            wrDec.baseCount = A[0];
         end else begin
            case (A)
               ADDR_CMD:     wrDec.cmd     = 1'b1;
               ADDR_MODE:    wrDec.mode    = 1'b1;
               ADDR_CLRFF:   wrDec.clrFF   = 1'b1;
               ADDR_MCLR:    wrDec.mClr    = 1'b1;
`ifdef MASK_DECODE_EN
               ADDR_REQ:     wrDec.request = 1'b1;
               ADDR_MASKBIT: wrDec.maskBit = 1'b1;
               ADDR_CLRMASK: wrDec.clrMask = 1'b1;
               ADDR_ALLMASK: wrDec.allMask = 1'b1;
`endif
               default: ;
            endcase
         end
      end else if (acc == ACC_RD) begin
         // Read 1101 would be the temporary register, which is not modelled.
         rdDec.status   = (A == ADDR_STATUS);
         rdDec.curAddr  = !A[3] & !A[0];
         rdDec.curCount = !A[3] & A[0];
      end
   end

endmodule

// File: rtl/dma_reference_model.sv
// Cycle-accurate strobe model of the 8237 CPU programming interface: edge tracking,
// registered write pulses, byte-pointer FF and channel select. Optional: MASK_DECODE_EN.
module dma_reference_model
   import dma_ref_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CS_N,
   input  logic       IOR_N,
   input  logic       IOW_N,
   input  logic [3:0] A,
   input  logic       programCondition,
   output logic       loadCommandReg,
   output logic       loadModeReg,
   output logic       loadBaseAddressReg,
   output logic       loadBaseWordCountReg,
   output logic       clearInternalFF,
   output logic       masterClear,
   output logic       readStatusReg,
   output logic       readCurrentAddressReg,
   output logic       readCurrentWordCountReg,
   output logic       loadIoDataBufferFromStatus,
   output logic [1:0] channelSel,
   output logic       upperByte,
   output logic       loadRequestReg,
   output logic       loadMaskBit,
   output logic       clearMaskReg,
   output logic       loadAllMask
);

   accType_t acc;
   wrDec_t   wrDec;
   rdDec_t   rdDec;
   logic     wrDone, rdDone;
   logic     wrFire, rdFire;
   logic     rdChanPulse;

   assign acc = accessType(CS_N, IOR_N, IOW_N, programCondition);

   dma_addr_decode uDecode (
      .A     (A),
      .acc   (acc),
      .wrDec (wrDec),
      .rdDec (rdDec)
   );

   // xxDone marks that this strobe-low phase already fired. It resets to 1 so a strobe
   // held low across reset must rise and fall again before it counts.
   assign wrFire = (acc == ACC_WR) & !wrDone;
   assign rdFire = (acc == ACC_RD) & !rdDone;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wrDone <= 1'b1;
         rdDone <= 1'b1;
      end else begin
         wrDone <= !IOW_N & (wrDone | (acc == ACC_WR));
         rdDone <= !IOR_N & (rdDone | (acc == ACC_RD));
      end
   end

   assign readStatusReg           = rdDec.status;
   assign readCurrentAddressReg   = rdDec.curAddr;
   assign readCurrentWordCountReg = rdDec.curCount;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         loadCommandReg             <= 1'b0;
         loadModeReg                <= 1'b0;
         loadBaseAddressReg         <= 1'b0;
         loadBaseWordCountReg       <= 1'b0;
         clearInternalFF            <= 1'b0;
         masterClear                <= 1'b0;
         loadIoDataBufferFromStatus <= 1'b0;
         rdChanPulse                <= 1'b0;
         channelSel                 <= 2'b00;
      end else begin
         loadCommandReg             <= wrFire & wrDec.cmd;
         loadModeReg                <= wrFire & wrDec.mode;
         loadBaseAddressReg         <= wrFire & wrDec.baseAddr;
         loadBaseWordCountReg       <= wrFire & wrDec.baseCount;
         clearInternalFF            <= wrFire & wrDec.clrFF;
         masterClear                <= wrFire & wrDec.mClr;
         loadIoDataBufferFromStatus <= rdFire & rdDec.status;
         rdChanPulse                <= rdFire & (rdDec.curAddr | rdDec.curCount);
         if ((wrFire & (wrDec.baseAddr | wrDec.baseCount)) |
             (rdFire & (rdDec.curAddr | rdDec.curCount)))
            channelSel <= A[2:1];
      end
   end

   // Byte pointer follows the registered strobes, so it flips the cycle after a pulse.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         upperByte <= 1'b0;
      else if (clearInternalFF | masterClear)
         upperByte <= 1'b0;
      else if (loadBaseAddressReg | loadBaseWordCountReg | rdChanPulse)
         upperByte <= ~upperByte;
   end

`ifdef MASK_DECODE_EN
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         loadRequestReg <= 1'b0;
         loadMaskBit    <= 1'b0;
         clearMaskReg   <= 1'b0;
         loadAllMask    <= 1'b0;
      end else begin
         loadRequestReg <= wrFire & wrDec.request;
         loadMaskBit    <= wrFire & wrDec.maskBit;
         clearMaskReg   <= wrFire & (wrDec.clrMask | wrDec.mClr);
         loadAllMask    <= wrFire & wrDec.allMask;
      end
   end
`else
   logic unusedMaskBits;
   assign unusedMaskBits = ^{wrDec.request, wrDec.maskBit, wrDec.clrMask, wrDec.allMask};
   assign loadRequestReg = 1'b0;
   assign loadMaskBit    = 1'b0;
   assign clearMaskReg   = 1'b0;
   assign loadAllMask    = 1'b0;
`endif

endmodule

// File: tb/tb_dma_reference_model.sv
// Directed self-checking bench for dma_reference_model; mask expectations follow MASK_DECODE_EN.
module tb_dma_reference_model;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic       CS_N = 1'b1;
   logic       IOR_N = 1'b1;
   logic       IOW_N = 1'b1;
   logic [3:0] A = 4'h0;
   logic       programCondition = 1'b1;
   logic       loadCommandReg, loadModeReg, loadBaseAddressReg, loadBaseWordCountReg;
   logic       clearInternalFF, masterClear, readStatusReg, readCurrentAddressReg;
   logic       readCurrentWordCountReg, loadIoDataBufferFromStatus, upperByte;
   logic [1:0] channelSel;
   logic       loadRequestReg, loadMaskBit, clearMaskReg, loadAllMask;

   int checks = 0;
   int errors = 0;
   int baseAddrPulses = 0;

   localparam logic [9:0] S_NONE    = 10'h000;
   localparam logic [9:0] S_CMD     = 10'h200;
   localparam logic [9:0] S_MODE    = 10'h100;
   localparam logic [9:0] S_MCLR    = 10'h010;
   localparam logic [9:0] S_CLRMASK = 10'h002;
   localparam logic [9:0] S_ALLMASK = 10'h001;

   logic [9:0] wrStrobes;
   assign wrStrobes = {loadCommandReg, loadModeReg, loadBaseAddressReg, loadBaseWordCountReg,
                       clearInternalFF, masterClear, loadRequestReg, loadMaskBit,
                       clearMaskReg, loadAllMask};

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (loadBaseAddressReg === 1'b1) baseAddrPulses++;

   dma_reference_model dut (
      .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
      .programCondition(programCondition),
      .loadCommandReg(loadCommandReg), .loadModeReg(loadModeReg),
      .loadBaseAddressReg(loadBaseAddressReg), .loadBaseWordCountReg(loadBaseWordCountReg),
      .clearInternalFF(clearInternalFF), .masterClear(masterClear),
      .readStatusReg(readStatusReg), .readCurrentAddressReg(readCurrentAddressReg),
      .readCurrentWordCountReg(readCurrentWordCountReg),
      .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus),
      .channelSel(channelSel), .upperByte(upperByte),
      .loadRequestReg(loadRequestReg), .loadMaskBit(loadMaskBit),
      .clearMaskReg(clearMaskReg), .loadAllMask(loadAllMask)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; programCondition = 1'b1;
   endtask

   task automatic busWrite(input logic [3:0] addr);
      CS_N = 1'b0; A = addr; IOW_N = 1'b0;
      cyc(); cyc();
      idle();
      cyc();
   endtask

   task automatic busRead(input logic [3:0] addr);
      CS_N = 1'b0; A = addr; IOR_N = 1'b0;
      cyc(); cyc();
      idle();
      cyc();
   endtask

   task automatic test_reset();
      #2 RESET_N = 1'b0;
      #2;
      checks++;
      if (wrStrobes !== S_NONE || loadIoDataBufferFromStatus !== 1'b0) begin
         errors++; $display("FAIL reset_strobes: got %h/%b expected 000/0", wrStrobes, loadIoDataBufferFromStatus);
      end
      checks++;
      if (upperByte !== 1'b0 || channelSel !== 2'd0) begin
         errors++; $display("FAIL reset_state: got ub=%b ch=%0d expected ub=0 ch=0", upperByte, channelSel);
      end
      cyc(); cyc();
      RESET_N = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_write_cmd();
      CS_N = 1'b0; A = 4'h8; IOW_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++;
         if (wrStrobes !== ((i == 1) ? S_CMD : S_NONE)) begin
            errors++; $display("FAIL write_cmd cycle %0d: got %h expected %h", i, wrStrobes, (i == 1) ? S_CMD : S_NONE);
         end
         cyc();
         if (i == 1) idle();
      end
   endtask

   task automatic test_addr_change();
      CS_N = 1'b0; A = 4'h8; IOW_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++;
         if (wrStrobes !== ((i == 1) ? S_CMD : S_NONE)) begin
            errors++; $display("FAIL addr_change cycle %0d: got %h expected %h", i, wrStrobes, (i == 1) ? S_CMD : S_NONE);
         end
         cyc();
         if (i == 1) A = 4'hB;
         if (i == 2) idle();
      end
   endtask

   task automatic test_byte_pointer();
      int n;
      busWrite(4'hC);
      checks++;
      if (upperByte !== 1'b0) begin errors++; $display("FAIL bp_clear0: got %b expected 0", upperByte); end
      n = baseAddrPulses;
      busWrite(4'h4);
      checks++;
      if (upperByte !== 1'b1 || channelSel !== 2'd2) begin
         errors++; $display("FAIL bp_first: got ub=%b ch=%0d expected ub=1 ch=2", upperByte, channelSel);
      end
      busWrite(4'h4);
      checks++;
      if (upperByte !== 1'b0 || channelSel !== 2'd2 || baseAddrPulses != n + 2) begin
         errors++; $display("FAIL bp_second: got ub=%b ch=%0d pulses=%0d expected ub=0 ch=2 pulses=2", upperByte, channelSel, baseAddrPulses - n);
      end
      busWrite(4'h7);
      checks++;
      if (upperByte !== 1'b1 || channelSel !== 2'd3) begin
         errors++; $display("FAIL bp_count_ch3: got ub=%b ch=%0d expected ub=1 ch=3", upperByte, channelSel);
      end
      busWrite(4'hC);
      checks++;
      if (upperByte !== 1'b0 || channelSel !== 2'd3) begin
         errors++; $display("FAIL bp_clearff: got ub=%b ch=%0d expected ub=0 ch=3", upperByte, channelSel);
      end
   endtask

   task automatic test_read_status();
      CS_N = 1'b0; A = 4'h8; IOR_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++;
         if (readStatusReg !== (i < 3) || loadIoDataBufferFromStatus !== (i == 1) || wrStrobes !== S_NONE) begin
            errors++; $display("FAIL read_status cycle %0d: got rd=%b buf=%b wr=%h expected rd=%b buf=%b wr=000",
                               i, readStatusReg, loadIoDataBufferFromStatus, wrStrobes, i < 3, i == 1);
         end
         cyc();
         if (i == 2) idle();
      end
   endtask

   task automatic test_read_channel();
      CS_N = 1'b0; A = 4'h2; IOR_N = 1'b0;
      @(negedge CLK);
      checks++;
      if (readCurrentAddressReg !== 1'b1 || readCurrentWordCountReg !== 1'b0 || readStatusReg !== 1'b0) begin
         errors++; $display("FAIL read_addr_level: got a=%b c=%b s=%b expected 1 0 0", readCurrentAddressReg, readCurrentWordCountReg, readStatusReg);
      end
      cyc(); cyc(); idle(); cyc();
      checks++;
      if (upperByte !== 1'b1 || channelSel !== 2'd1) begin
         errors++; $display("FAIL read_addr_ptr: got ub=%b ch=%0d expected ub=1 ch=1", upperByte, channelSel);
      end
      CS_N = 1'b0; A = 4'h3; IOR_N = 1'b0;
      @(negedge CLK);
      checks++;
      if (readCurrentWordCountReg !== 1'b1 || readCurrentAddressReg !== 1'b0) begin
         errors++; $display("FAIL read_count_level: got c=%b a=%b expected 1 0", readCurrentWordCountReg, readCurrentAddressReg);
      end
      cyc(); cyc(); idle(); cyc();
      checks++;
      if (upperByte !== 1'b0 || channelSel !== 2'd1 || loadIoDataBufferFromStatus !== 1'b0) begin
         errors++; $display("FAIL read_count_ptr: got ub=%b ch=%0d buf=%b expected ub=0 ch=1 buf=0", upperByte, channelSel, loadIoDataBufferFromStatus);
      end
   endtask

   task automatic test_no_strobe();
      for (int k = 0; k < 3; k++) begin
         A = 4'hB;
         case (k)
            0: begin CS_N = 1'b0; programCondition = 1'b0; IOW_N = 1'b0; end
            1: begin CS_N = 1'b1; IOW_N = 1'b0; end
            default: begin CS_N = 1'b0; IOR_N = 1'b0; IOW_N = 1'b0; end
         endcase
         for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (wrStrobes !== S_NONE || {readStatusReg, readCurrentAddressReg, readCurrentWordCountReg,
                                         loadIoDataBufferFromStatus} !== 4'b0) begin
               errors++; $display("FAIL no_strobe case %0d cycle %0d: got wr=%h rd=%b%b%b%b expected all 0", k, i, wrStrobes,
                                  readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, loadIoDataBufferFromStatus);
            end
            cyc();
         end
         idle(); cyc(); cyc();
      end
   endtask

   task automatic test_master_clear_and_mask();
      logic [9:0] expMclr, expAll;
`ifdef MASK_DECODE_EN
      expMclr = S_MCLR | S_CLRMASK;
      expAll  = S_ALLMASK;
`else
      expMclr = S_MCLR;
      expAll  = S_NONE;
`endif
      busWrite(4'h4);
      checks++;
      if (upperByte !== 1'b1) begin errors++; $display("FAIL mclr_setup: got ub=%b expected 1", upperByte); end
      CS_N = 1'b0; A = 4'hD; IOW_N = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if (wrStrobes !== ((i == 1) ? expMclr : S_NONE)) begin
            errors++; $display("FAIL master_clear cycle %0d: got %h expected %h", i, wrStrobes, (i == 1) ? expMclr : S_NONE);
         end
         cyc();
         if (i == 1) idle();
      end
      checks++;
      if (upperByte !== 1'b0) begin errors++; $display("FAIL mclr_ptr: got ub=%b expected 0", upperByte); end
      CS_N = 1'b0; A = 4'hF; IOW_N = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if (wrStrobes !== ((i == 1) ? expAll : S_NONE)) begin
            errors++; $display("FAIL all_mask cycle %0d: got %h expected %h", i, wrStrobes, (i == 1) ? expAll : S_NONE);
         end
         cyc();
         if (i == 1) idle();
      end
   endtask

   task automatic test_reset_mid_write();
      busWrite(4'h2);
      checks++;
      if (upperByte !== 1'b1 || channelSel !== 2'd1) begin
         errors++; $display("FAIL rst_setup: got ub=%b ch=%0d expected ub=1 ch=1", upperByte, channelSel);
      end
      CS_N = 1'b0; A = 4'hB; IOW_N = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      checks++;
      if (wrStrobes !== S_NONE || upperByte !== 1'b0 || channelSel !== 2'd0) begin
         errors++; $display("FAIL rst_immediate: got wr=%h ub=%b ch=%0d expected 000 0 0", wrStrobes, upperByte, channelSel);
      end
      cyc(); cyc();
      checks++;
      if (loadModeReg !== 1'b0) begin errors++; $display("FAIL rst_held_mode: got %b expected 0", loadModeReg); end
      RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if (wrStrobes !== S_NONE) begin
            errors++; $display("FAIL rst_held_low cycle %0d: got %h expected 000", i, wrStrobes);
         end
         cyc();
      end
      IOW_N = 1'b1;
      cyc();
      IOW_N = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if (wrStrobes !== ((i == 1) ? S_MODE : S_NONE)) begin
            errors++; $display("FAIL rst_rearm cycle %0d: got %h expected %h", i, wrStrobes, (i == 1) ? S_MODE : S_NONE);
         end
         cyc();
         if (i == 1) idle();
      end
   endtask

   initial begin
      test_reset();
      test_write_cmd();
      test_addr_change();
      test_byte_pointer();
      test_read_status();
      test_read_channel();
      test_no_strobe();
      test_master_clear_and_mask();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
